id_ex_control: RTL and testbench
================================

Name: id_ex_control

Overview:
- Main control decoder for the ID stage, plus the ID/EX control pipeline register with load-use hazard detection.
- Decodes the RV32 opcode into ALUOp and datapath control signals, and forwards Funct ({instr[30], funct3}) to the EX-stage ALU_Control.
- Inserts bubbles on load-use hazards and on branch flush.
- Sits between the IF/ID register and the EX stage; it is the producer of the ALUOp/Funct pair the ALU control consumes.

Parameters:
- REG_W, 5, register-index width.
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 means stall is always 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  IF/ID holds a real instruction
- Instruction  in  32  IF/ID instruction word
- flush  in  1  branch taken in EX; kill the ID instruction
- stall  out  1  combinational; hold PC and IF/ID this cycle
- illegal_instr  out  1  registered one-cycle pulse for an undecodable valid opcode
- ex_valid  out  1  ID/EX holds a real instruction
- ex_ALUOp  out  2  to ALU_Control
- ex_Funct  out  4  {Instruction[30], Instruction[14:12]}
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch  out  1 each
- ex_rd, ex_rs1, ex_rs2  out  REG_W  register indices

Behaviour:
- Reset (async, active-high): all ex_* outputs = 0 and illegal_instr = 0. stall evaluates from the zeroed registers, so it is 0.
- Decode (combinational on Instruction[6:0]); fields are ALUOp, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, uses_rs2:
  - 0110011 R-type: 10, 1, 0, 0, 0, 0, 0, uses_rs2 = 1
  - 0000011 ld: 00, 1, 1, 0, 1, 1, 0, uses_rs2 = 0
  - 0100011 sd: 00, 0, 0, 1, 0, 1, 0, uses_rs2 = 1
  - 1100011 beq: 01, 0, 0, 0, 0, 0, 1, uses_rs2 = 1
  - 0010011 addi: 00, 1, 0, 0, 0, 1, 0, uses_rs2 = 0
  - Any other opcode is illegal: all controls 0.
- Field extraction: rd = Instruction[11:7], rs1 = Instruction[19:15], rs2 = Instruction[24:20].
- Hazard, combinational:
  - haz = HAZARD_EN && instr_valid && ex_valid && ex_MemRead && ex_rd != 0 && (ex_rd == rs1 || (uses_rs2 && ex_rd == rs2))
  - stall = haz && !flush
- Register update, priority highest first, each rising edge:
  1. flush: load a bubble (ex_valid and all controls = 0; ex_Funct, ex_rd, ex_rs1, ex_rs2 = 0).
  2. haz: load a bubble. IF/ID holds externally, so the same instruction re-presents next cycle.
  3. instr_valid and the opcode is legal: load the decoded controls, ex_Funct and the register fields; ex_valid = 1.
  4. Otherwise (invalid, or illegal opcode): load a bubble.
- illegal_instr: registered, = instr_valid && illegal && !flush; high for exactly one cycle per offending instruction.
- Latency: exactly 1 cycle from the ID instruction to the ex_* outputs.
- Load-use costs exactly one bubble: after the bubble, ex_MemRead = 0, so haz drops.
- ld to x0 never stalls (ex_rd == 0).
- Simultaneous flush and haz: flush wins and stall = 0.
- Reset asserted mid-stream: outputs clear immediately (asynchronously). First decode happens on the first edge after deassertion.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM
  - ALUOp constants: ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10
  - a ctrl_t bundle: ALUOp, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch
- One sub-module, main_decoder: purely combinational, opcode in, ctrl_t + uses_rs2 + illegal out. The hazard logic and pipeline register stay in id_ex_control.

Test Plan:
- Reset with garbage Instruction, release, instr_valid = 0 → ex_valid = 0, all ex_* = 0, stall = 0.
- R-type add x3,x1,x2 (0x002081B3) → next cycle: ex_ALUOp = 10, ex_Funct = 0000, ex_RegWrite = 1, ex_rd = 3, ex_valid = 1. sub (0x402081B3) → ex_Funct = 1000.
- ld x5,0(x1) then add x6,x5,x2 → stall = 1 for exactly 1 cycle, one bubble (ex_valid = 0), then the add issues with ex_ALUOp = 10. Repeat with ld to x0 → no stall.
- ld x5 then beq x1,x5 (rs2 hazard) → stall = 1. ld x5 then addi x7,x0,x5-in-rs2-field (uses_rs2 = 0) → no stall.
- flush = 1 during a stall condition → stall = 0, bubble loaded. flush with a valid sd → ex_MemWrite = 0 next cycle.
- Opcode 1111111 with instr_valid = 1 → illegal_instr pulses 1 cycle, ex_valid = 0. Same opcode with flush = 1 → no pulse. Assert reset mid-stream → ex_* clear before the next clk edge.

Source files
------------

// File: rtl/id_ex_control_pkg.sv
// Shared opcode/ALUOp constants and the control bundle
// carried from ID into the ID/EX register.
package id_ex_control_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] ALUOp;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       ALUSrc;
        logic       Branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_control_main_decoder.sv
// Combinational main decoder: opcode to control bundle,
// rs2-usage flag and illegal-opcode flag.
module main_decoder
    import id_ex_control_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs2,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                ctrl.ALUOp    = ALUOP_FUNCT;
                ctrl.RegWrite = 1'b1;
                uses_rs2      = 1'b1;
            end
            (opcode == OP_LOAD): begin
                ctrl.ALUOp    = ALUOP_ADD;
                ctrl.RegWrite = 1'b1;
                ctrl.MemRead  = 1'b1;
                ctrl.MemtoReg = 1'b1;
                ctrl.ALUSrc   = 1'b1;
            end
            (opcode == OP_STORE): begin
                ctrl.ALUOp    = ALUOP_ADD;
                ctrl.MemWrite = 1'b1;
                ctrl.ALUSrc   = 1'b1;
                uses_rs2      = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                ctrl.ALUOp  = ALUOP_SUB;
                ctrl.Branch = 1'b1;
                uses_rs2    = 1'b1;
            end
            (opcode == OP_IMM): begin
                ctrl.ALUOp    = ALUOP_ADD;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrc   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_control.sv
// ID-stage control: main decode, load-use hazard detection
// and the ID/EX control pipeline register.
module id_ex_control
    import id_ex_control_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int HAZARD_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      Instruction,
    input  logic             flush,
    output logic             stall,
    output logic             illegal_instr,
    output logic             ex_valid,
    output logic [1:0]       ex_ALUOp,
    output logic [3:0]       ex_Funct,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_MemtoReg,
    output logic             ex_ALUSrc,
    output logic             ex_Branch,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2
);

    ctrl_t            dec_ctrl;
    ctrl_t            ex_ctrl;
    logic             uses_rs2;
    logic             illegal;
    logic             haz;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [3:0]       funct;
    logic             bits_unused;

    main_decoder u_dec (
        .opcode   (Instruction[6:0]),
        .ctrl     (dec_ctrl),
        .uses_rs2 (uses_rs2),
        .illegal  (illegal)
    );

    assign rd          = REG_W'(Instruction[11:7]);
    assign rs1         = REG_W'(Instruction[19:15]);
    assign rs2         = REG_W'(Instruction[24:20]);
    assign funct       = {Instruction[30], Instruction[14:12]};
    assign bits_unused = ^{Instruction[31], Instruction[29:25]};

    // Load in EX whose destination feeds this instruction
    assign haz = (HAZARD_EN != 0) && instr_valid && ex_valid
               && ex_ctrl.MemRead && (ex_rd != '0)
               && ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));

    assign stall = haz && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= CTRL_NOP;
            ex_Funct      <= '0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= instr_valid && illegal && !flush;
            if (flush || haz || !instr_valid || illegal) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_NOP;
                ex_Funct <= '0;
                ex_rd    <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
            end else begin
                ex_valid <= 1'b1;
                ex_ctrl  <= dec_ctrl;
                ex_Funct <= funct;
                ex_rd    <= rd;
                ex_rs1   <= rs1;
                ex_rs2   <= rs2;
            end
        end
    end

    assign ex_ALUOp    = ex_ctrl.ALUOp;
    assign ex_RegWrite = ex_ctrl.RegWrite;
    assign ex_MemRead  = ex_ctrl.MemRead;
    assign ex_MemWrite = ex_ctrl.MemWrite;
    assign ex_MemtoReg = ex_ctrl.MemtoReg;
    assign ex_ALUSrc   = ex_ctrl.ALUSrc;
    assign ex_Branch   = ex_ctrl.Branch;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed self-checking bench for id_ex_control.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_id_ex_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] Instruction;
    logic        flush;
    logic        stall;
    logic        illegal_instr;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [3:0]  ex_Funct;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_ALUSrc;
    logic        ex_Branch;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
    localparam logic [31:0] SUB_3_1_2  = 32'h402081B3;
    localparam logic [31:0] LD_5_1     = 32'h0000B283;
    localparam logic [31:0] LD_0_1     = 32'h0000B003;
    localparam logic [31:0] ADD_6_5_2  = 32'h00228333;
    localparam logic [31:0] ADD_6_0_2  = 32'h00200333;
    localparam logic [31:0] BEQ_1_5    = 32'h00508063;
    localparam logic [31:0] ADDI_7_0_5 = 32'h00500393;
    localparam logic [31:0] SD_2_1     = 32'h0020B023;
    localparam logic [31:0] BAD_OP     = 32'h0000007F;

    always #5 clk = ~clk;

    id_ex_control #(.REG_W(5), .HAZARD_EN(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .Instruction   (Instruction),
        .flush         (flush),
        .stall         (stall),
        .illegal_instr (illegal_instr),
        .ex_valid      (ex_valid),
        .ex_ALUOp      (ex_ALUOp),
        .ex_Funct      (ex_Funct),
        .ex_RegWrite   (ex_RegWrite),
        .ex_MemRead    (ex_MemRead),
        .ex_MemWrite   (ex_MemWrite),
        .ex_MemtoReg   (ex_MemtoReg),
        .ex_ALUSrc     (ex_ALUSrc),
        .ex_Branch     (ex_Branch),
        .ex_rd         (ex_rd),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic fl);
        instr_valid = v;
        Instruction = ins;
        flush       = fl;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        Instruction = 32'hDEADBEEF;
        flush       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 32'hDEADBEEF, 1'b0);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluop", 32'(ex_ALUOp), 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_illegal", 32'(illegal_instr), 32'd0);
        tick();
        chk("invalid_bubble", 32'(ex_valid), 32'd0);
        chk("invalid_regwrite", 32'(ex_RegWrite), 32'd0);

        // R-type add then sub
        drive(1'b1, ADD_3_1_2, 1'b0);
        chk("add_stall", 32'(stall), 32'd0);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_aluop", 32'(ex_ALUOp), 32'd2);
        chk("add_funct", 32'(ex_Funct), 32'd0);
        chk("add_regwrite", 32'(ex_RegWrite), 32'd1);
        chk("add_alusrc", 32'(ex_ALUSrc), 32'd0);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_rs1", 32'(ex_rs1), 32'd1);
        chk("add_rs2", 32'(ex_rs2), 32'd2);
        drive(1'b1, SUB_3_1_2, 1'b0);
        tick();
        chk("sub_funct", 32'(ex_Funct), 32'd8);

        // load-use on rs1: one bubble
        drive(1'b1, LD_5_1, 1'b0);
        tick();
        chk("ld_memread", 32'(ex_MemRead), 32'd1);
        chk("ld_memtoreg", 32'(ex_MemtoReg), 32'd1);
        chk("ld_alusrc", 32'(ex_ALUSrc), 32'd1);
        chk("ld_aluop", 32'(ex_ALUOp), 32'd0);
        chk("ld_funct", 32'(ex_Funct), 32'd3);
        chk("ld_rd", 32'(ex_rd), 32'd5);
        drive(1'b1, ADD_6_5_2, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_bubble_mr", 32'(ex_MemRead), 32'd0);
        chk("lu_stall_drop", 32'(stall), 32'd0);
        tick();
        chk("lu_issue_valid", 32'(ex_valid), 32'd1);
        chk("lu_issue_aluop", 32'(ex_ALUOp), 32'd2);
        chk("lu_issue_rd", 32'(ex_rd), 32'd6);
        chk("lu_issue_rs1", 32'(ex_rs1), 32'd5);

        // load to x0 never stalls
        drive(1'b1, LD_0_1, 1'b0);
        tick();
        chk("ldx0_memread", 32'(ex_MemRead), 32'd1);
        drive(1'b1, ADD_6_0_2, 1'b0);
        chk("ldx0_stall", 32'(stall), 32'd0);
        tick();
        chk("ldx0_issue", 32'(ex_valid), 32'd1);
        chk("ldx0_rd", 32'(ex_rd), 32'd6);

        // rs2 hazard through beq
        drive(1'b1, LD_5_1, 1'b0);
        tick();
        drive(1'b1, BEQ_1_5, 1'b0);
        chk("beq_stall", 32'(stall), 32'd1);
        tick();
        chk("beq_bubble", 32'(ex_valid), 32'd0);
        chk("beq_stall_drop", 32'(stall), 32'd0);
        tick();
        chk("beq_branch", 32'(ex_Branch), 32'd1);
        chk("beq_aluop", 32'(ex_ALUOp), 32'd1);
        chk("beq_regwrite", 32'(ex_RegWrite), 32'd0);

        // addi ignores its rs2 field
        drive(1'b1, LD_5_1, 1'b0);
        tick();
        drive(1'b1, ADDI_7_0_5, 1'b0);
        chk("addi_stall", 32'(stall), 32'd0);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_alusrc", 32'(ex_ALUSrc), 32'd1);
        chk("addi_rd", 32'(ex_rd), 32'd7);

        // flush beats hazard
        drive(1'b1, LD_5_1, 1'b0);
        tick();
        drive(1'b1, ADD_6_5_2, 1'b1);
        chk("flushhaz_stall", 32'(stall), 32'd0);
        tick();
        chk("flushhaz_valid", 32'(ex_valid), 32'd0);
        chk("flushhaz_rw", 32'(ex_RegWrite), 32'd0);

        // flushed store, then a real one
        drive(1'b1, SD_2_1, 1'b1);
        tick();
        chk("flushsd_mw", 32'(ex_MemWrite), 32'd0);
        chk("flushsd_valid", 32'(ex_valid), 32'd0);
        drive(1'b1, SD_2_1, 1'b0);
        tick();
        chk("sd_mw", 32'(ex_MemWrite), 32'd1);
        chk("sd_alusrc", 32'(ex_ALUSrc), 32'd1);
        chk("sd_rs2", 32'(ex_rs2), 32'd2);
        chk("sd_regwrite", 32'(ex_RegWrite), 32'd0);

        // illegal opcode
        drive(1'b1, BAD_OP, 1'b0);
        chk("ill_pre", 32'(illegal_instr), 32'd0);
        tick();
        chk("ill_pulse", 32'(illegal_instr), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd0);
        drive(1'b0, BAD_OP, 1'b0);
        tick();
        chk("ill_one_cycle", 32'(illegal_instr), 32'd0);
        drive(1'b1, BAD_OP, 1'b1);
        tick();
        chk("ill_flushed", 32'(illegal_instr), 32'd0);

        // asynchronous reset mid-stream
        drive(1'b1, ADD_3_1_2, 1'b0);
        tick();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_rw", 32'(ex_RegWrite), 32'd0);
        chk("async_rst_rd", 32'(ex_rd), 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, ADD_3_1_2, 1'b0);
        chk("post_rst_held", 32'(ex_valid), 32'd0);
        tick();
        chk("post_rst_decode", 32'(ex_valid), 32'd1);
        chk("post_rst_rd", 32'(ex_rd), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
